// File: rtl/edf_ic_pkg.sv
// rtl/edf_ic_pkg.sv - shared types and constants for the EDF interrupt claim block
package edf_ic_pkg;

  // Claim handshake phases
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OFFER   = 2'd1,
    ST_RETRY   = 2'd2,
    ST_SERVICE = 2'd3
  } state_e;

  localparam int unsigned DefaultAckTimeout = 8;
  localparam logic [7:0]  RetryCntMax       = 8'hFF;

endpackage

// File: rtl/edf_timeout_cnt.sv
// rtl/edf_timeout_cnt.sv - offer timeout counter with clear, enable and expire flag
module edf_timeout_cnt
  import edf_ic_pkg::*;
#(
  parameter int unsigned Limit = DefaultAckTimeout
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam logic [7:0] LastVal = 8'(Limit - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Clear wins over enable so a fresh offer always starts from zero
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Counter register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Expire marks the last offer cycle the hart is allowed to acknowledge in
  assign expire_o = (cnt_q == LastVal);

endmodule

// File: rtl/edf_irq_claim.sv
// rtl/edf_irq_claim.sv - offers an EDF winner to the hart and tracks claim/service/complete
module edf_irq_claim
  import edf_ic_pkg::*;
#(
  parameter  int unsigned NrParIrqs  = 4,
  parameter  int unsigned AckTimeout = DefaultAckTimeout,
  localparam int unsigned IdWidth    = $clog2(NrParIrqs)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 ic_valid_i,
  input  logic [IdWidth-1:0]   ic_id_i,
  output logic                 ic_ready_o,
  output logic                 ic_claim_o,
  output logic                 ic_complete_o,
  output logic [IdWidth-1:0]   ic_ret_id_o,
  output logic                 core_irq_o,
  output logic [IdWidth-1:0]   core_id_o,
  input  logic                 core_ack_i,
  input  logic                 core_done_i,
  input  logic [IdWidth-1:0]   core_done_id_i,
  output logic [NrParIrqs-1:0] in_service_o,
  output logic [7:0]           retry_cnt_o,
  output logic                 err_o
);

  state_e             state_q, state_d;
  logic [IdWidth-1:0] id_q, id_d;
  logic               claim_q, claim_d;
  logic               complete_q, complete_d;
  logic [IdWidth-1:0] ret_id_q, ret_id_d;
  logic [7:0]         retry_cnt_q, retry_cnt_d;
  logic               err_q, err_d;

  logic accept;
  logic ack_ok;
  logic timeout;
  logic done_ok;
  logic tmo_clr;
  logic tmo_en;
  logic tmo_expire;

  assign accept  = (state_q == ST_IDLE) && ic_valid_i;
  assign ack_ok  = (state_q == ST_OFFER) && core_ack_i;
  // An ack on the expiring cycle still counts, so timeout requires no ack
  assign timeout = (state_q == ST_OFFER) && !core_ack_i && tmo_expire;
  assign done_ok = (state_q == ST_SERVICE) && core_done_i && (core_done_id_i == id_q);
  assign tmo_clr = accept;
  assign tmo_en  = (state_q == ST_OFFER) && !core_ack_i && !tmo_expire;

  edf_timeout_cnt #(
    .Limit(AckTimeout)
  ) u_timeout_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (tmo_clr),
    .en_i    (tmo_en),
    .expire_o(tmo_expire)
  );

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (accept) state_d = ST_OFFER;
      ST_OFFER: begin
        if (ack_ok) begin
          state_d = ST_SERVICE;
        end else if (timeout) begin
          state_d = ST_RETRY;
        end
      end
      ST_RETRY:   state_d = ST_IDLE;
      ST_SERVICE: if (done_ok) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    ic_ready_o   = 1'b0;
    core_irq_o   = 1'b0;
    core_id_o    = '0;
    in_service_o = '0;
    unique case (state_q)
      ST_IDLE:    ic_ready_o = 1'b1;
      ST_OFFER: begin
        core_irq_o = 1'b1;
        core_id_o  = id_q;
      end
      ST_SERVICE: in_service_o[id_q] = 1'b1;
      default:    ic_ready_o = 1'b0;
    endcase
  end

  // Latched id, one-cycle controller pulses, retry count and sticky error
  always_comb begin
    id_d        = id_q;
    claim_d     = 1'b0;
    complete_d  = 1'b0;
    ret_id_d    = '0;
    retry_cnt_d = retry_cnt_q;
    err_d       = err_q;
    if (accept) begin
      id_d = ic_id_i;
    end
    if (ack_ok) begin
      claim_d  = 1'b1;
      ret_id_d = id_q;
    end
    if (done_ok) begin
      complete_d = 1'b1;
      ret_id_d   = id_q;
    end
    if (timeout && (retry_cnt_q != RetryCntMax)) begin
      retry_cnt_d = retry_cnt_q + 8'd1;
    end
    if (core_done_i && !done_ok) begin
      err_d = 1'b1;
    end
  end

  // Datapath registers; reset drops any pending pulse so an abandoned transaction reports nothing
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      id_q        <= '0;
      claim_q     <= 1'b0;
      complete_q  <= 1'b0;
      ret_id_q    <= '0;
      retry_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      id_q        <= id_d;
      claim_q     <= claim_d;
      complete_q  <= complete_d;
      ret_id_q    <= ret_id_d;
      retry_cnt_q <= retry_cnt_d;
      err_q       <= err_d;
    end
  end

  assign ic_claim_o    = claim_q;
  assign ic_complete_o = complete_q;
  assign ic_ret_id_o   = ret_id_q;
  assign retry_cnt_o   = retry_cnt_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_edf_irq_claim.sv
// tb/tb_edf_irq_claim.sv - randomized and directed self-checking bench for edf_irq_claim
module tb_edf_irq_claim;

  localparam int ACK_TO = 8;

  logic       clk = 1'b0;
  logic       rst_i = 1'b0;
  logic       ic_valid_i = 1'b0;
  logic [1:0] ic_id_i = '0;
  logic       ic_ready_o;
  logic       ic_claim_o;
  logic       ic_complete_o;
  logic [1:0] ic_ret_id_o;
  logic       core_irq_o;
  logic [1:0] core_id_o;
  logic       core_ack_i = 1'b0;
  logic       core_done_i = 1'b0;
  logic [1:0] core_done_id_i = '0;
  logic [3:0] in_service_o;
  logic [7:0] retry_cnt_o;
  logic       err_o;

  int total = 0;
  int bad   = 0;

  // Reference model: where the single transaction currently is
  bit         m_offer;
  int         m_age;
  bit         m_retry;
  bit         m_serv;
  logic [1:0] m_id;
  bit         m_claim;
  bit         m_comp;
  logic [1:0] m_ret;
  int         m_retries;
  bit         m_err;

  always #5 clk = ~clk;

  edf_irq_claim #(
    .NrParIrqs (4),
    .AckTimeout(ACK_TO)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .ic_valid_i    (ic_valid_i),
    .ic_id_i       (ic_id_i),
    .ic_ready_o    (ic_ready_o),
    .ic_claim_o    (ic_claim_o),
    .ic_complete_o (ic_complete_o),
    .ic_ret_id_o   (ic_ret_id_o),
    .core_irq_o    (core_irq_o),
    .core_id_o     (core_id_o),
    .core_ack_i    (core_ack_i),
    .core_done_i   (core_done_i),
    .core_done_id_i(core_done_id_i),
    .in_service_o  (in_service_o),
    .retry_cnt_o   (retry_cnt_o),
    .err_o         (err_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_next(input bit rst, input bit v, input logic [1:0] id,
                            input bit ack, input bit done, input logic [1:0] did);
    m_claim = 0;
    m_comp  = 0;
    m_ret   = '0;
    if (rst) begin
      m_offer = 0; m_age = 0; m_retry = 0; m_serv = 0; m_id = '0;
      m_retries = 0; m_err = 0;
      return;
    end
    if (done && !(m_serv && did == m_id)) m_err = 1;
    if (!m_offer && !m_retry && !m_serv) begin
      if (v) begin
        m_id = id; m_offer = 1; m_age = 0;
      end
    end else if (m_offer) begin
      if (ack) begin
        m_offer = 0; m_serv = 1; m_claim = 1; m_ret = m_id;
      end else if (m_age == ACK_TO - 1) begin
        m_offer = 0; m_retry = 1;
        if (m_retries < 255) m_retries++;
      end else begin
        m_age++;
      end
    end else if (m_retry) begin
      m_retry = 0;
    end else if (done && did == m_id) begin
      m_serv = 0; m_comp = 1; m_ret = m_id;
    end
  endtask

  task automatic model_cmp();
    logic [3:0] exp_svc;
    exp_svc = m_serv ? (4'b0001 << m_id) : 4'b0000;
    chk("m_ready",   ic_ready_o,    !m_offer && !m_retry && !m_serv);
    chk("m_irq",     core_irq_o,    m_offer);
    chk("m_core_id", core_id_o,     m_offer ? m_id : 2'd0);
    chk("m_claim",   ic_claim_o,    m_claim);
    chk("m_comp",    ic_complete_o, m_comp);
    chk("m_ret_id",  ic_ret_id_o,   m_ret);
    chk("m_insvc",   in_service_o,  exp_svc);
    chk("m_retry",   retry_cnt_o,   m_retries);
    chk("m_err",     err_o,         m_err);
  endtask

  // Drive one cycle of inputs, advance the model, then sample just after the edge
  task automatic step(input bit rst, input bit v, input logic [1:0] id,
                      input bit ack, input bit done, input logic [1:0] did);
    rst_i          = rst;
    ic_valid_i     = v;
    ic_id_i        = id;
    core_ack_i     = ack;
    core_done_i    = done;
    core_done_id_i = did;
    model_next(rst, v, id, ack, done, did);
    @(posedge clk);
    #1;
    model_cmp();
  endtask

  initial begin
    bit         r, v, a, d;
    logic [1:0] id, did;

    step(1, 0, 0, 0, 0, 0);
    chk("rst_ready", ic_ready_o, 1);
    chk("rst_retry", retry_cnt_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_insvc", in_service_o, 0);

    // Offer id 2, ack in the third offer cycle while ic_id_i wanders
    step(0, 1, 2, 0, 0, 0);
    chk("s1_irq1", core_irq_o, 1);
    chk("s1_id1", core_id_o, 2);
    step(0, 1, 2'($urandom), 0, 0, 0);
    chk("s1_irq2", core_irq_o, 1);
    chk("s1_id2", core_id_o, 2);
    step(0, 1, 2'($urandom), 0, 0, 0);
    chk("s1_irq3", core_irq_o, 1);
    chk("s1_id3", core_id_o, 2);
    step(0, 1, 2'($urandom), 1, 0, 0);
    chk("s1_claim", ic_claim_o, 1);
    chk("s1_ret", ic_ret_id_o, 2);
    chk("s1_insvc", in_service_o, 4'b0100);
    chk("s1_irq_off", core_irq_o, 0);
    step(0, 1, 2'($urandom), 0, 0, 0);
    chk("s1_claim_end", ic_claim_o, 0);
    chk("s1_ret_zero", ic_ret_id_o, 0);

    // Matching done completes
    step(0, 0, 0, 0, 1, 2);
    chk("s2_comp", ic_complete_o, 1);
    chk("s2_ret", ic_ret_id_o, 2);
    chk("s2_insvc", in_service_o, 0);
    chk("s2_ready", ic_ready_o, 1);
    step(0, 0, 0, 0, 0, 0);
    chk("s2_comp_end", ic_complete_o, 0);

    // Offer id 1 with no ack: eight offer cycles, one retry cycle, then re-offer id 3
    step(0, 1, 1, 0, 0, 0);
    for (int k = 1; k < ACK_TO; k++) begin
      chk("s3_irq", core_irq_o, 1);
      step(0, 0, 0, 0, 0, 0);
    end
    chk("s3_irq8", core_irq_o, 1);
    chk("s3_id8", core_id_o, 1);
    step(0, 1, 3, 0, 0, 0);
    chk("s3_retry_irq", core_irq_o, 0);
    chk("s3_retry_cnt", retry_cnt_o, 1);
    chk("s3_retry_busy", ic_ready_o, 0);
    step(0, 1, 3, 0, 0, 0);
    chk("s3_idle_ready", ic_ready_o, 1);
    step(0, 1, 3, 0, 0, 0);
    chk("s3_reoffer_irq", core_irq_o, 1);
    chk("s3_reoffer_id", core_id_o, 3);

    // Ack on the last allowed offer cycle wins over timeout
    for (int k = 1; k < ACK_TO; k++) step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("s4_claim", ic_claim_o, 1);
    chk("s4_ret", ic_ret_id_o, 3);
    chk("s4_retry_cnt", retry_cnt_o, 1);
    chk("s4_insvc", in_service_o, 4'b1000);
    step(0, 0, 0, 0, 1, 3);
    chk("s4_comp", ic_complete_o, 1);

    // Mismatched done flags error but keeps service; matching done then completes
    step(0, 1, 2, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 1);
    chk("s5_err", err_o, 1);
    chk("s5_insvc", in_service_o, 4'b0100);
    chk("s5_no_comp", ic_complete_o, 0);
    step(0, 0, 0, 0, 1, 2);
    chk("s5_comp", ic_complete_o, 1);
    chk("s5_ret", ic_ret_id_o, 2);

    // Reset while in service abandons the transaction
    step(0, 1, 2, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("s6_insvc", in_service_o, 0);
    chk("s6_err", err_o, 0);
    chk("s6_comp", ic_complete_o, 0);
    chk("s6_ready", ic_ready_o, 1);

    // Done and ack while idle: error set, ack ignored
    step(0, 0, 0, 1, 1, 0);
    chk("s7_err", err_o, 1);
    chk("s7_claim", ic_claim_o, 0);
    chk("s7_ready", ic_ready_o, 1);
    step(1, 0, 0, 0, 0, 0);

    // Over 300 timeouts saturate the retry count
    for (int k = 0; k < 3100; k++) step(0, 1, 2'($urandom), 0, 0, 0);
    chk("s8_sat", retry_cnt_o, 255);
    step(1, 0, 0, 0, 0, 0);

    // Random traffic against the model
    for (int k = 0; k < 4000; k++) begin
      r   = ($urandom_range(0, 199) == 0);
      v   = 1'($urandom_range(0, 1));
      id  = 2'($urandom);
      a   = ($urandom_range(0, 5) == 0);
      d   = ($urandom_range(0, 3) == 0);
      did = ($urandom_range(0, 3) == 0) ? 2'($urandom) : m_id;
      step(r, v, id, a, d, did);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
